load_store_unit: RTL
====================

# load_store_unit

Sits between the RV32I execute stage and `zeroDelayRAM`, converting one load or store request (byte, halfword or word, signed or unsigned) into word-aligned accesses on the RAM port. It performs sub-word stores as read-modify-write over the 32-bit RAM word and sign- or zero-extends sub-word loads. It flags misaligned, out-of-range and illegal-width accesses without touching RAM, and reports completion with a one-cycle `done` pulse.

## Interface
- `dataW`, 32: data word width; only 32 is supported.
- `RAMAddrSize`, 8: byte-address width of the RAM port.
- `clock` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `req` in 1: request strobe, sampled only in IDLE.
- `isStore` in 1: 1 = store, 0 = load.
- `funct3` in 3: 000 B, 001 H, 010 W, 100 BU, 101 HU; stores accept only 000/001/010.
- `addr` in 32: byte address.
- `storeData` in dataW: store operand; the low byte/half/word is used.
- `busy` out 1: high from the cycle after request acceptance until `done`.
- `done` out 1: one-cycle completion pulse.
- `fault` out 1: valid with `done`; 1 = access rejected.
- `loadData` out dataW: extended load result; held until the next load completes.
- `RAMAddr` out RAMAddrSize: word-aligned address, `{addr[RAMAddrSize-1:2],2'b00}`.
- `DataIn` out dataW: RAM write data.
- `RAMWriteControl` out 1: RAM write enable; the RAM writes at the rising edge.
- `RAMOut` in dataW: zero-delay RAM read data for `RAMAddr`.

## Operation
- States: IDLE, READ, WRITE, DONE.
- IDLE with `req`=1: latch `isStore`, `funct3`, `addr`, `storeData`. Next state:
  - Fault → DONE, with the fault flag set.
  - Load → READ.
  - SW → WRITE.
  - SB/SH → READ.
- Fault conditions, checked in this order:
  - Illegal `funct3`.
  - `addr[31:RAMAddrSize]` ≠ 0.
  - H/HU/SH with `addr[0]`=1.
  - W/SW with `addr[1:0]`≠0.
- READ: `RAMOut` is captured at the edge.
  - For a load, the extracted and extended value goes to `loadData` and the next state is DONE.
  - For SB/SH, the captured word is held and the next state is WRITE.
- Byte lane = `addr[1:0]`; half lane = `addr[1]`. Layout is little-endian: byte 0 = bits 7:0.
- Load extension:
  - B/H: sign-extend.
  - BU/HU: zero-extend.
  - W: unchanged.
- WRITE: `RAMWriteControl`=1 for exactly one cycle.
  - `DataIn` = `storeData` for SW.
  - For SB/SH, `DataIn` = the captured word with only the addressed byte/half replaced by `storeData[7:0]`/`[15:0]`.
  - Next state is DONE.
- DONE: `done`=1 and `fault` = latched flag; next state IDLE. `busy`=0 in DONE.
- `req` is ignored in all states except IDLE, and in IDLE during the cycle `done` is high. A request held high re-issues on the cycle after DONE.
- A faulted access never asserts `RAMWriteControl` and never updates `loadData`.
- `RAMAddr` is driven from the latched address in READ/WRITE and is 0 in IDLE/DONE. `DataIn` is 0 outside WRITE.

## Timing
- Request accepted at edge N.
  - Fault: `done` high in cycle N+1.
  - SW: `done` high in cycle N+2.
  - Load: `done` high in cycle N+2.
  - SB/SH: `done` high in cycle N+3.
- `loadData` is valid from the same edge that raises `done`.
- The RAM word is updated at the edge ending WRITE, so it is visible to the first request accepted after `done`.
- Reset values: state IDLE; `busy`, `done`, `fault`, `RAMWriteControl` = 0; `RAMAddr`, `DataIn`, `loadData` = 0.
- Reset mid-operation: the next state is IDLE and no `done` pulse is issued. `RAMWriteControl` is forced 0 combinationally while `reset`=1, so a reset during WRITE produces no write.
- Simultaneous `reset` and `req`: reset wins and the request is dropped.

## Test plan
- SW 0xDEADBEEF @0x40, then LW @0x40 → word at 0x40 = 0xDEADBEEF; `loadData`=0xDEADBEEF; `done` at N+2 for each access; `fault`=0.
- Word 0x11223344 @0x40, SB 0xA5 @0x41 → word 0x1122A544, `done` at N+3, `RAMWriteControl` high 1 cycle; then LB @0x41 → 0xFFFFFFA5 and LBU @0x41 → 0x000000A5.
- SH 0x8001 @0x42 on 0x1122A544 → word 0x8001A544; then LH @0x42 → 0xFFFF8001, LHU @0x42 → 0x00008001, LB @0x40 → 0x00000044.
- Fault cases: LW @0x42, SH @0x43, `funct3`=011 and LW @0x100 → each gives `done`+`fault`=1 at N+1; `RAMWriteControl` never high; `loadData` and RAM contents unchanged.
- Assert `reset` for 1 cycle during the WRITE cycle of SB @0x44 → no RAM write, no `done`, `busy`=0 next cycle; a following LW @0x44 returns the old word.
- Pulse `req` again during READ of an SH → ignored: exactly one `done`, one write.

Source files
------------

// File: rtl/load_store_unit.sv
// load_store_unit: converts one RV32I load/store request into word-aligned
// accesses on a zero-delay RAM port. Sub-word stores are done as
// read-modify-write, and sub-word loads are sign- or zero-extended.
// Misaligned, out-of-range and illegal-width accesses are rejected without
// touching RAM.
module load_store_unit #(
  parameter int dataW       = 32,
  parameter int RAMAddrSize = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   req,
  input  logic                   isStore,
  input  logic [2:0]             funct3,
  input  logic [31:0]            addr,
  input  logic [dataW-1:0]       storeData,
  output logic                   busy,
  output logic                   done,
  output logic                   fault,
  output logic [dataW-1:0]       loadData,
  output logic [RAMAddrSize-1:0] RAMAddr,
  output logic [dataW-1:0]       DataIn,
  output logic                   RAMWriteControl,
  input  logic [dataW-1:0]       RAMOut
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t                 state_q, state_d;
  logic                   fault_p0;
  logic                   is_store_p0;
  logic [2:0]             funct3_p0;
  logic [RAMAddrSize-1:0] addr_p0;
  logic [dataW-1:0]       store_data_p0;
  logic [dataW-1:0]       rd_word_p1;
  logic                   accept;

  // Rejection test on the raw request; any single condition rejects it.
  function automatic logic access_fault(input logic st, input logic [2:0] f3,
                                        input logic [31:0] a);
    logic illegal, range_err, half_err, word_err;
    illegal   = st ? (f3 > 3'b010) : ((f3 == 3'b011) || (f3[2:1] == 2'b11));
    range_err = |a[31:RAMAddrSize];
    half_err  = (f3[1:0] == 2'b01) && a[0];
    word_err  = (f3 == 3'b010) && (a[1:0] != 2'b00);
    return illegal | range_err | half_err | word_err;
  endfunction

  // Pull the addressed byte/half out of a little-endian word and extend it.
  function automatic logic [dataW-1:0] load_extend(input logic [dataW-1:0] w,
                                                   input logic [2:0] f3,
                                                   input logic [1:0] lane);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{lane, 3'b000} +: 8];
    h = w[{lane[1], 4'b0000} +: 16];
    case (f3)
      3'b000:  return {{(dataW-8){b[7]}}, b};
      3'b001:  return {{(dataW-16){h[15]}}, h};
      3'b100:  return {{(dataW-8){1'b0}}, b};
      3'b101:  return {{(dataW-16){1'b0}}, h};
      default: return w;
    endcase
  endfunction

  // Replace only the addressed byte/half of the captured word.
  function automatic logic [dataW-1:0] store_merge(input logic [dataW-1:0] w,
                                                   input logic [dataW-1:0] d,
                                                   input logic [2:0] f3,
                                                   input logic [1:0] lane);
    logic [dataW-1:0] m;
    m = w;
    case (f3)
      3'b000:  m[{lane, 3'b000} +: 8] = d[7:0];
      3'b001:  m[{lane[1], 4'b0000} +: 16] = d[15:0];
      default: m = d;
    endcase
    return m;
  endfunction

  assign accept = (state_q == IDLE) && req;

  // Control state: FSM register, fault flag and load result.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      fault_p0 <= 1'b0;
      loadData <= '0;
    end else begin
      state_q <= state_d;
      if (accept)
        fault_p0 <= access_fault(isStore, funct3, addr);
      if ((state_q == READ) && !is_store_p0)
        loadData <= load_extend(RAMOut, funct3_p0, addr_p0[1:0]);
    end
  end

  // Request latch and captured RAM word (datapath, no reset needed).
  always_ff @(posedge clock) begin
    if (accept) begin
      is_store_p0   <= isStore;
      funct3_p0     <= funct3;
      addr_p0       <= addr[RAMAddrSize-1:0];
      store_data_p0 <= storeData;
    end
    if (state_q == READ)
      rd_word_p1 <= RAMOut;
  end

  // Next-state and RAM/handshake outputs decoded from the current state.
  always_comb begin
    state_d         = state_q;
    busy            = 1'b0;
    done            = 1'b0;
    fault           = 1'b0;
    RAMAddr         = '0;
    DataIn          = '0;
    RAMWriteControl = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          if (access_fault(isStore, funct3, addr)) state_d = DONE;
          else if (!isStore)                       state_d = READ;
          else if (funct3 == 3'b010)               state_d = WRITE;
          else                                     state_d = READ;
        end
      end
      READ: begin
        busy    = 1'b1;
        RAMAddr = {addr_p0[RAMAddrSize-1:2], 2'b00};
        state_d = is_store_p0 ? WRITE : DONE;
      end
      WRITE: begin
        busy            = 1'b1;
        RAMAddr         = {addr_p0[RAMAddrSize-1:2], 2'b00};
        DataIn          = store_merge(rd_word_p1, store_data_p0, funct3_p0, addr_p0[1:0]);
        RAMWriteControl = !reset;
        state_d         = DONE;
      end
      DONE: begin
        done    = 1'b1;
        fault   = fault_p0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
